// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for the dual-port FIFO_MEM array: show-ahead, registered flags.
// Optional sticky overflow/underflow reporting is enabled by defining FIFO_PTR_CTRL_ERR_EN.
module fifo_ptr_ctrl #(
  parameter int AW        = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_PUSH,
  input  logic          I_POP,
`ifdef FIFO_PTR_CTRL_ERR_EN
  input  logic          I_CLR_ERR,
  output logic          O_OVERFLOW,
  output logic          O_UNDERFLOW,
`endif
  output logic          O_MEM_WR_EN,
  output logic [AW-1:0] O_MEM_WR_ADDR,
  output logic [AW-1:0] O_MEM_RD_ADDR,
  output logic          O_FULL,
  output logic          O_EMPTY,
  output logic          O_ALMOST_FULL,
  output logic          O_ALMOST_EMPTY,
  output logic [AW:0]   O_COUNT
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        afull_q, afull_d;
  logic        aempty_q, aempty_d;
  logic        push_ok, pop_ok;

  // Acceptance uses only registered flags, so requests never feed the flags combinationally.
  assign push_ok = I_PUSH & ~full_q;
  assign pop_ok  = I_POP & ~empty_q;

  always_comb begin
    wptr_d   = wptr_q + (AW+1)'(push_ok);
    rptr_d   = rptr_q + (AW+1)'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    full_d   = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (32'(count_d) >= AFULL_TH);
    aempty_d = (32'(count_d) <= AEMPTY_TH);
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Write enable is gated by reset so a held push cannot write while reset is asserted.
  assign O_MEM_WR_EN    = push_ok & I_RST_N;
  assign O_MEM_WR_ADDR  = wptr_q[AW-1:0];
  assign O_MEM_RD_ADDR  = rptr_q[AW-1:0];
  assign O_FULL         = full_q;
  assign O_EMPTY        = empty_q;
  assign O_ALMOST_FULL  = afull_q;
  assign O_ALMOST_EMPTY = aempty_q;
  assign O_COUNT        = count_q;

`ifdef FIFO_PTR_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new drop event in the same cycle as the clear keeps the flag set.
  always_comb begin
    ovf_d = (I_PUSH & full_q) | (ovf_q & ~I_CLR_ERR);
    udf_d = (I_POP & empty_q) | (udf_q & ~I_CLR_ERR);
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign O_OVERFLOW  = ovf_q;
  assign O_UNDERFLOW = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with a behavioural FIFO_MEM array attached.
// Sticky error checks are compiled in when FIFO_PTR_CTRL_ERR_EN is defined.
module tb_fifo_ptr_ctrl;

  localparam int AW = 4;

  logic          I_CLK;
  logic          I_RST_N;
  logic          I_PUSH;
  logic          I_POP;
  logic          O_MEM_WR_EN;
  logic [AW-1:0] O_MEM_WR_ADDR;
  logic [AW-1:0] O_MEM_RD_ADDR;
  logic          O_FULL;
  logic          O_EMPTY;
  logic          O_ALMOST_FULL;
  logic          O_ALMOST_EMPTY;
  logic [AW:0]   O_COUNT;
`ifdef FIFO_PTR_CTRL_ERR_EN
  logic          I_CLR_ERR;
  logic          O_OVERFLOW;
  logic          O_UNDERFLOW;
`endif

  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] mem [1<<AW];

  int n_checks;
  int n_fail;

  fifo_ptr_ctrl #(.AW(AW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .I_CLK          (I_CLK),
    .I_RST_N        (I_RST_N),
    .I_PUSH         (I_PUSH),
    .I_POP          (I_POP),
`ifdef FIFO_PTR_CTRL_ERR_EN
    .I_CLR_ERR      (I_CLR_ERR),
    .O_OVERFLOW     (O_OVERFLOW),
    .O_UNDERFLOW    (O_UNDERFLOW),
`endif
    .O_MEM_WR_EN    (O_MEM_WR_EN),
    .O_MEM_WR_ADDR  (O_MEM_WR_ADDR),
    .O_MEM_RD_ADDR  (O_MEM_RD_ADDR),
    .O_FULL         (O_FULL),
    .O_EMPTY        (O_EMPTY),
    .O_ALMOST_FULL  (O_ALMOST_FULL),
    .O_ALMOST_EMPTY (O_ALMOST_EMPTY),
    .O_COUNT        (O_COUNT)
  );

  // Clock / reset
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // FIFO_MEM stand-in: synchronous write, asynchronous read
  always @(posedge I_CLK) begin
    if (O_MEM_WR_EN) mem[O_MEM_WR_ADDR] <= wr_data;
  end
  assign rd_data = mem[O_MEM_RD_ADDR];

  // Driver / check tasks
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},  32'(O_EMPTY), 32'd1);
    chk({tag, "_full"},   32'(O_FULL), 32'd0);
    chk({tag, "_count"},  32'(O_COUNT), 32'd0);
    chk({tag, "_ae"},     32'(O_ALMOST_EMPTY), 32'd1);
    chk({tag, "_af"},     32'(O_ALMOST_FULL), 32'd0);
    chk({tag, "_wr_en"},  32'(O_MEM_WR_EN), 32'd0);
    chk({tag, "_wraddr"}, 32'(O_MEM_WR_ADDR), 32'd0);
    chk({tag, "_rdaddr"}, 32'(O_MEM_RD_ADDR), 32'd0);
`ifdef FIFO_PTR_CTRL_ERR_EN
    chk({tag, "_ovf"},    32'(O_OVERFLOW), 32'd0);
    chk({tag, "_udf"},    32'(O_UNDERFLOW), 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    I_PUSH   = 1'b0;
    I_POP    = 1'b0;
    wr_data  = 8'h00;
`ifdef FIFO_PTR_CTRL_ERR_EN
    I_CLR_ERR = 1'b0;
`endif
    I_RST_N = 1'b1;
    #1;
    I_RST_N = 1'b0;

    // 1. reset then idle
    tick();
    tick();
    chk_reset_state("rst");
    I_RST_N = 1'b1;
    tick();
    tick();
    chk_reset_state("idle");

    // 2. fill with A0..AF, then drain in order
    for (int i = 0; i < 16; i++) begin
      I_PUSH  = 1'b1;
      wr_data = 8'hA0 + 8'(i);
      #1;
      chk("fill_wr_en", 32'(O_MEM_WR_EN), 32'd1);
      chk("fill_wr_addr", 32'(O_MEM_WR_ADDR), 32'(i));
      tick();
      chk("fill_count", 32'(O_COUNT), 32'(i + 1));
      chk("fill_empty", 32'(O_EMPTY), 32'd0);
      chk("fill_full", 32'(O_FULL), 32'(i == 15));
      chk("fill_af", 32'(O_ALMOST_FULL), 32'(i + 1 >= 14));
      chk("fill_ae", 32'(O_ALMOST_EMPTY), 32'(i + 1 <= 2));
      if (i == 0) chk("fallthrough_data", 32'(rd_data), 32'hA0);
    end
    I_PUSH = 1'b0;
    for (int i = 0; i < 16; i++) begin
      I_POP = 1'b1;
      #1;
      chk("drain_data", 32'(rd_data), 32'(8'hA0 + 8'(i)));
      chk("drain_wr_en", 32'(O_MEM_WR_EN), 32'd0);
      tick();
      chk("drain_count", 32'(O_COUNT), 32'(15 - i));
      chk("drain_empty", 32'(O_EMPTY), 32'(i == 15));
      chk("drain_full", 32'(O_FULL), 32'd0);
      chk("drain_ae", 32'(O_ALMOST_EMPTY), 32'(15 - i <= 2));
    end
    I_POP = 1'b0;

    // 3. fill with B0..BF, then push 0xFF with pop while full
    for (int i = 0; i < 16; i++) begin
      I_PUSH  = 1'b1;
      wr_data = 8'hB0 + 8'(i);
      tick();
    end
    chk("full_count", 32'(O_COUNT), 32'd16);
    chk("full_flag", 32'(O_FULL), 32'd1);
    I_PUSH  = 1'b1;
    I_POP   = 1'b1;
    wr_data = 8'hFF;
    #1;
    chk("full_pp_wr_en", 32'(O_MEM_WR_EN), 32'd0);
    chk("full_pp_data", 32'(rd_data), 32'hB0);
    tick();
    I_PUSH = 1'b0;
    I_POP  = 1'b0;
    chk("full_pp_count", 32'(O_COUNT), 32'd15);
    chk("full_pp_full", 32'(O_FULL), 32'd0);
`ifdef FIFO_PTR_CTRL_ERR_EN
    chk("ovf_set", 32'(O_OVERFLOW), 32'd1);
    tick();
    chk("ovf_sticky", 32'(O_OVERFLOW), 32'd1);
    I_CLR_ERR = 1'b1;
    tick();
    I_CLR_ERR = 1'b0;
    chk("ovf_clear", 32'(O_OVERFLOW), 32'd0);
`endif
    for (int i = 1; i < 16; i++) begin
      I_POP = 1'b1;
      #1;
      chk("after_drop_data", 32'(rd_data), 32'(8'hB0 + 8'(i)));
      tick();
    end
    I_POP = 1'b0;
    chk("after_drop_empty", 32'(O_EMPTY), 32'd1);

    // 4. pop alone while empty, then pop+push 0x55 while empty
    I_POP = 1'b1;
    tick();
    chk("udf_pop_count", 32'(O_COUNT), 32'd0);
    chk("udf_pop_rdaddr", 32'(O_MEM_RD_ADDR), 32'd0);
    I_PUSH  = 1'b1;
    wr_data = 8'h55;
    #1;
    chk("empty_pp_wr_en", 32'(O_MEM_WR_EN), 32'd1);
    tick();
    I_PUSH = 1'b0;
    I_POP  = 1'b0;
    chk("empty_pp_count", 32'(O_COUNT), 32'd1);
    chk("empty_pp_empty", 32'(O_EMPTY), 32'd0);
    chk("empty_pp_data", 32'(rd_data), 32'h55);
`ifdef FIFO_PTR_CTRL_ERR_EN
    chk("udf_set", 32'(O_UNDERFLOW), 32'd1);
    I_CLR_ERR = 1'b1;
    I_POP     = 1'b1;
    tick();
    I_CLR_ERR = 1'b0;
    I_POP     = 1'b0;
    chk("udf_clear", 32'(O_UNDERFLOW), 32'd0);
`else
    I_POP = 1'b1;
    tick();
    I_POP = 1'b0;
`endif
    chk("empty_again", 32'(O_EMPTY), 32'd1);

    // 5. preload 3, then 40 cycles of push+pop across two wraps
    for (int i = 0; i < 3; i++) begin
      I_PUSH  = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    I_POP = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 8'hC3 + 8'(k);
      #1;
      chk("steady_data", 32'(rd_data), 32'(8'hC0 + 8'(k)));
      tick();
      chk("steady_count", 32'(O_COUNT), 32'd3);
    end
    I_POP = 1'b0;

    // 6. push up to count 9, then async reset while a push is pending
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    chk("pre_rst_count", 32'(O_COUNT), 32'd9);
    chk("pre_rst_data", 32'(rd_data), 32'hE8);
    wr_data = 8'h77;
    #1;
    chk("pre_rst_wr_en", 32'(O_MEM_WR_EN), 32'd1);
    #2;
    I_RST_N = 1'b0;
    #1;
    chk_reset_state("async_rst");
    I_PUSH = 1'b0;
    tick();
    I_RST_N = 1'b1;
    tick();
    I_PUSH  = 1'b1;
    wr_data = 8'hE0;
    #1;
    chk("post_rst_wr_addr", 32'(O_MEM_WR_ADDR), 32'd0);
    tick();
    I_PUSH = 1'b0;
    chk("post_rst_count", 32'(O_COUNT), 32'd1);
    chk("post_rst_data", 32'(rd_data), 32'hE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
